// File: rtl/sram_pkg.sv
// Shared types and defaults for the 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } sram_state_t;

  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned SRAM_AW_DEFAULT   = 18;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: splits each 32-bit access into two halfword
// phases on an asynchronous 16-bit SRAM and freezes the core via ready.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  localparam int unsigned CW   = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  sram_state_t        state, state_nx;
  logic [CW-1:0]      cnt;
  logic               in_phase;
  logic               phase_end;
  logic [SRAM_AW-2:0] word;

  // Upper offset bits are dropped, so out-of-range addresses wrap.
  assign word      = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
  assign phase_end = (cnt == LAST);

  always_comb begin
    state_nx    = state;
    in_phase    = 1'b0;
    ready       = 1'b1;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    case (state)
      S_IDLE: begin
        ready = ~(wr_en | rd_en);
        if (wr_en)      state_nx = S_WR_LO;
        else if (rd_en) state_nx = S_RD_LO;
      end
      S_WR_LO, S_WR_HI: begin
        in_phase    = 1'b1;
        ready       = 1'b0;
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_addr   = {word, state == S_WR_HI};
        sram_dq_out = (state == S_WR_HI) ? write_data[31:16] : write_data[15:0];
        if (phase_end) state_nx = (state == S_WR_HI) ? S_DONE : S_WR_HI;
      end
      S_RD_LO, S_RD_HI: begin
        in_phase  = 1'b1;
        ready     = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = {word, state == S_RD_HI};
        if (phase_end) state_nx = (state == S_RD_HI) ? S_DONE : S_RD_HI;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (!rst) ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      // A phase only ends on phase_end, so this also clears cnt on phase entry.
      cnt   <= (in_phase && !phase_end) ? cnt + CW'(1) : '0;
      if (state == S_RD_LO && phase_end) read_data[15:0]  <= sram_dq_in;
      if (state == S_RD_HI && phase_end) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM, transaction-level
// reference model compared every cycle, directed cases plus random traffic.
module tb_sram_controller;

  localparam int unsigned AC   = 2;
  localparam int unsigned AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 2 * AC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n, sram_oe_n, sram_dq_oe;
  logic [15:0]   sram_dq_out, sram_dq_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR(BASE),
    .ACCESS_CYCLES(AC),
    .SRAM_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  // Behavioural asynchronous SRAM.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) % (32'd1 << (AW - 1));
  endfunction

  // Transaction-level model: pos counts edges since the request was accepted
  // (-1 idle, 1..2*AC in the halfword phases, 2*AC+1 the completion cycle).
  logic [31:0] model_mem [0:(1<<(AW-1))-1];
  bit          model_live = 1'b0;
  int          pos = -1;
  bit          lat_wr;
  logic [31:0] lat_word, lat_data;
  logic [31:0] exp_rd;

  always @(posedge clk) begin
    if (!rst) begin
      model_live <= 1'b1;
      pos        <= -1;
      exp_rd     <= '0;
    end else if (model_live) begin
      if (pos < 0) begin
        if (wr_en || rd_en) begin
          pos      <= 1;
          lat_wr   <= wr_en;
          lat_word <= word_of(address);
          lat_data <= write_data;
        end
      end else if (pos == LAT) begin
        pos <= -1;
      end else begin
        pos <= pos + 1;
        if (pos == 2 * AC) begin
          if (lat_wr) model_mem[lat_word] <= lat_data;
          else        exp_rd <= model_mem[lat_word];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit          ph, hi, exp_ready;
    logic [17:0] exp_addr;
    if (model_live) begin
      ph = (pos >= 1) && (pos <= 2 * AC);
      hi = pos > int'(AC);
      if (!rst)         exp_ready = 1'b1;
      else if (pos < 0) exp_ready = !(wr_en || rd_en);
      else              exp_ready = !ph;
      check("ready", ready, exp_ready);
      check("sram_we_n", sram_we_n, !(ph && lat_wr));
      check("sram_oe_n", sram_oe_n, !(ph && !lat_wr));
      check("sram_dq_oe", sram_dq_oe, ph && lat_wr);
      if (ph) begin
        exp_addr = {lat_word[AW-2:0], hi};
        check("sram_addr", sram_addr, exp_addr);
      end
      if (ph && lat_wr)
        check("sram_dq_out", sram_dq_out, hi ? lat_data[31:16] : lat_data[15:0]);
      // LO half of a read is already updated during the HI phase.
      if (!(ph && !lat_wr && hi))
        check("read_data", read_data, exp_rd);
    end
  end

  // Called at posedge+1 with the controller idle; holds the request through
  // completion, like a frozen core, and returns the count of ready-low cycles.
  task automatic do_op(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, output int lows);
    wr_en = w; rd_en = r; address = a; write_data = d;
    lows = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      if (!ready) lows++;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int lows;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    for (int i = 0; i < (1 << (AW - 1)); i++) model_mem[i] = '0;

    // Reset with a write request pending.
    rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
    address = BASE; write_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", sram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;

    // Write then read back.
    do_op(1, 0, BASE + 8, 32'hDEADBEEF, lows);
    check("wr_ready_low_cycles", lows, LAT);
    check("wr_sram4", sram_mem[4], 16'hBEEF);
    check("wr_sram5", sram_mem[5], 16'hDEAD);
    do_op(0, 1, 32'd1032, 32'h0, lows);
    check("rd_ready_low_cycles", lows, LAT);
    check("rd_data", read_data, 32'hDEADBEEF);

    // Address wrap.
    do_op(1, 0, BASE + (32'd1 << (AW + 1)) + 4, 32'h12345678, lows);
    check("wrap_sram2", sram_mem[2], 16'h5678);
    check("wrap_sram3", sram_mem[3], 16'h1234);
    do_op(0, 1, 32'd1028, 32'h0, lows);
    check("wrap_rd_data", read_data, 32'h12345678);

    // Both requests asserted: write wins, read_data untouched.
    do_op(1, 1, 32'd1040, 32'hA5A5_0F0F, lows);
    check("both_sram8", sram_mem[8], 16'h0F0F);
    check("both_sram9", sram_mem[9], 16'hA5A5);
    check("both_read_data", read_data, 32'h12345678);

    // Reset during RD_HI.
    rd_en = 1'b1; address = 32'd1032;
    repeat (AC + 1) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", ready, 1);
    check("midrst_read_data", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", ready, 1);
    @(posedge clk); #1;
    do_op(0, 1, 32'd1032, 32'h0, lows);
    check("midrst_rd_data", read_data, 32'hDEADBEEF);

    // Random traffic, including back-to-back ops and wrapping addresses.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, d;
      bit w, r;
      int unsigned sel;
      sel = $urandom_range(0, 19);
      w = (sel < 9) || (sel == 19);
      r = !w || (sel == 19);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      do_op(w, r, a, d, lows);
      check("rand_ready_low_cycles", lows, LAT);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
